systolic_skew_feeder: RTL and testbench

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder_pkg.sv | 24 ++
 rtl/systolic_skew_feeder_delay_line.sv | 41 ++++
 rtl/systolic_skew_feeder.sv | 119 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants for the systolic array front end.
// Purpose : array geometry constants, feeder FSM state encodings and a small
//           helper used to size the flush counter.
// Contents: ARR_HEIGHT/SYS_HEIGHT (array geometry), ST_IDLE/ST_STREAM/ST_FLUSH
//           (feeder state encodings), state_t, flush_w().
package systolic_skew_feeder_pkg;

  // Downstream array geometry: row lanes = ARR_HEIGHT * SYS_HEIGHT.
  localparam int ARR_HEIGHT = 2;
  localparam int SYS_HEIGHT = 2;
  localparam int ARR_LANES  = ARR_HEIGHT * SYS_HEIGHT;

  // Feeder FSM state encodings.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // Width of a counter that must reach lanes-2 (at least 1 bit).
  function automatic int flush_w(input int lanes);
    return (lanes > 2) ? $clog2(lanes - 1) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay_line.sv
// skew_delay_line
// Purpose : fixed-depth shift register carrying a data word and its valid bit.
//           Data entering without valid is forced to zero, so the output is
//           zero whenever o_valid is low.
// Ports   : i_clk, i_reset (sync, active-high), i_valid/i_data (input word),
//           o_valid/o_data (word delayed by DEPTH rising edges).
module skew_delay_line
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_valid <= '0;
    end else begin
      r_data[0]  <= i_valid ? i_data : '0;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Purpose : accepts a tile of k_len column vectors and emits them skewed in
//           time, lane k delayed by 1+k cycles, ready to drive the in_a edge
//           of a systolic array. After the last vector it flushes LANES-1
//           cycles of zeros and pulses done.
// Ports   : clk, reset (sync, active-high); start/k_len (tile command);
//           in_valid/in_ready/in_data (vector input); out_a/out_lane_valid/
//           out_valid (skewed stream); busy, done (status); o_dbg_state (FSM).
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
//           in_ready depends only on registered state, never on in_valid;
//           the source must hold in_data stable while in_valid is high.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] out_a,
  output logic [LANES-1:0]       out_lane_valid,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             o_dbg_state
);

  localparam int FW = flush_w(LANES);

  state_t           r_state;
  logic [CNT_W-1:0] r_klen;
  logic [CNT_W-1:0] r_cnt;
  logic [FW-1:0]    r_flush;
  logic             r_done;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_accept  = in_valid && (r_state == ST_STREAM);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_klen  <= '0;
      r_cnt   <= '0;
      r_flush <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Being IDLE during a done cycle is what makes back-to-back starts work.
          if (start) begin
            if (k_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_klen  <= k_len;
              r_cnt   <= '0;
              r_state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_klen) begin
              if (LANES == 1) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_FLUSH;
                r_flush <= '0;
              end
            end
          end
        end
        ST_FLUSH: begin
          // LANES-1 flush cycles: done lands with the last lane of the last vector.
          if (r_flush == FW'(LANES - 2)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_flush <= r_flush + FW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Lane k is delayed k+1 edges; bubbles enter as zero words with valid low.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH(k + 1),
      .WIDTH(WIDTH)
    ) u_delay (
      .i_clk   (clk),
      .i_reset (reset),
      .i_valid (w_accept),
      .i_data  (in_data[k*WIDTH +: WIDTH]),
      .o_valid (out_lane_valid[k]),
      .o_data  (out_a[k*WIDTH +: WIDTH])
    );
  end

  assign in_ready    = (r_state == ST_STREAM);
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign out_valid   = |out_lane_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder (LANES=4, WIDTH=16).
// The reference model is a cycle schedule: each accepted vector is stored
// by acceptance cycle, and lane k in cycle c shows the vector accepted at
// edge c-k. Tile status (busy/ready/done) is scheduled forward from start
// and last-acceptance events.
module tb_systolic_skew_feeder;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int DW    = LANES * WIDTH;
  localparam int N     = 1024;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] k_len;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [DW-1:0]    out_a;
  logic [LANES-1:0] out_lane_valid;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [1:0]       o_dbg_state;

  systolic_skew_feeder #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .k_len          (k_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_a          (out_a),
    .out_lane_valid (out_lane_valid),
    .out_valid      (out_valid),
    .busy           (busy),
    .done           (done),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  int            cyc;
  int            n_checks;
  int            n_pass;
  int            m_left;
  bit            acc_v  [N];
  logic [DW-1:0] acc_d  [N];
  bit            e_busy [N];
  bit            e_ready[N];
  bit            e_done [N];
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
  endtask

  function automatic logic [DW-1:0] mkvec(input int n);
    logic [DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*WIDTH +: WIDTH] = WIDTH'((k << 8) | n);
    return v;
  endfunction

  // Predict the effect of the inputs applied in cycle cyc on the next edge.
  task automatic model_step(input bit rst, input bit st, input logic [CNT_W-1:0] kl,
                            input bit iv, input logic [DW-1:0] d);
    int n;
    n = cyc;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        acc_v[i] = 0; e_busy[i] = 0; e_ready[i] = 0; e_done[i] = 0;
      end
      exp_q.delete();
      m_left = 0;
    end else if (!e_busy[n]) begin
      if (st) begin
        if (kl == 0) e_done[n+1] = 1;
        else begin
          m_left = int'(kl);
          e_busy[n+1] = 1; e_ready[n+1] = 1;
        end
      end
    end else if (e_ready[n]) begin
      if (iv) begin
        acc_v[n+1] = 1;
        acc_d[n+1] = d;
        exp_q.push_back(d[(LANES-1)*WIDTH +: WIDTH]);
        m_left--;
      end
      if (m_left == 0) begin
        for (int j = 1; j < LANES; j++) e_busy[n+j] = 1;
        e_done[n+LANES] = 1;
      end else begin
        e_busy[n+1] = 1; e_ready[n+1] = 1;
      end
    end
  endtask

  task automatic compare();
    logic [DW-1:0]    ea;
    logic [LANES-1:0] elv;
    logic [WIDTH-1:0] q;
    ea  = '0;
    elv = '0;
    for (int k = 0; k < LANES; k++) begin
      if (cyc - k >= 0 && acc_v[cyc-k]) begin
        ea[k*WIDTH +: WIDTH] = acc_d[cyc-k][k*WIDTH +: WIDTH];
        elv[k] = 1'b1;
      end
    end
    check("out_a",          out_a, ea);
    check("out_lane_valid", DW'(out_lane_valid), DW'(elv));
    check("out_valid",      DW'(out_valid), DW'(|elv));
    check("in_ready",       DW'(in_ready), DW'(e_ready[cyc]));
    check("busy",           DW'(busy), DW'(e_busy[cyc]));
    check("done",           DW'(done), DW'(e_done[cyc]));
    if (out_lane_valid[LANES-1] === 1'b1) begin
      if (exp_q.size() == 0) check("sb_extra", 1, 0);
      else begin
        q = exp_q.pop_front();
        check("sb_last_lane", DW'(out_a[(LANES-1)*WIDTH +: WIDTH]), DW'(q));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit st, input logic [CNT_W-1:0] kl,
                       input bit iv, input logic [DW-1:0] d);
    if (cyc >= N - 2*LANES) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, N - 2*LANES);
      $fatal(1, "cycle budget exceeded");
    end
    reset = rst; start = st; k_len = kl; in_valid = iv; in_data = d;
    model_step(rst, st, kl, iv, d);
    @(posedge clk);
    cyc++;
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, '0);
  endtask

  // Idle until the DUT should be in a done cycle (bounded), then confirm it.
  task automatic wait_done_cycle();
    int t;
    t = 0;
    while (!e_done[cyc] && t < 20) begin
      idle(1);
      t++;
    end
    check("done_wait", DW'(done), DW'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0; n_checks = 0; n_pass = 0; m_left = 0;
    reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0;

    // Reset for two cycles: all outputs zero.
    drive(1, 0, '0, 0, '0);
    drive(1, 0, '0, 0, '0);
    idle(1);

    // Basic tile k_len=3, vectors back to back.
    drive(0, 1, 8'd3, 0, '0);
    for (int v = 0; v < 3; v++) drive(0, 0, '0, 1, mkvec(v));
    idle(6);

    // Bubble between V0 and V1.
    drive(0, 1, 8'd2, 0, '0);
    drive(0, 0, '0, 1, mkvec(0));
    drive(0, 0, '0, 0, mkvec(9));
    drive(0, 0, '0, 1, mkvec(1));
    idle(6);

    // Zero-length tile.
    drive(0, 1, 8'd0, 1, mkvec(7));
    idle(3);

    // Reset after the second acceptance of a 4-vector tile, then a fresh tile.
    drive(0, 1, 8'd4, 0, '0);
    drive(0, 0, '0, 1, mkvec(0));
    drive(0, 0, '0, 1, mkvec(1));
    drive(1, 0, '0, 1, mkvec(2));
    idle(2);
    drive(0, 1, 8'd2, 0, '0);
    drive(0, 0, '0, 1, mkvec(4));
    drive(0, 0, '0, 1, mkvec(5));
    idle(6);

    // Start during STREAM is ignored; start in the done cycle is taken.
    drive(0, 1, 8'd3, 0, '0);
    drive(0, 1, 8'd5, 1, mkvec(0));
    drive(0, 1, 8'd1, 1, mkvec(1));
    drive(0, 0, '0, 1, mkvec(2));
    wait_done_cycle();
    drive(0, 1, 8'd2, 1, mkvec(8));
    drive(0, 0, '0, 1, mkvec(10));
    drive(0, 0, '0, 1, mkvec(11));
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      drive(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 5) == 0),
            CNT_W'($urandom_range(0, 6)),
            ($urandom_range(0, 3) != 0),
            {$urandom, $urandom});
    end
    idle(8);
    check("sb_drained", DW'(exp_q.size()), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
